// File: rtl/resta_pkg.sv
// Shared types and helpers for the bit-serial subtractor resta_seq.
// Optional build macro used by resta_seq: RESTA_SIGNED_RESULT_EN.
package resta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 3;
  localparam int OUT_W_DEFAULT = 2 * WIDTH_DEFAULT;

  // Bits needed to count 0 .. value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Purely combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/resta_seq.sv
// Bit-serial unsigned subtractor xi - yi, LSB first, with start/done handshake.
// Build macro RESTA_SIGNED_RESULT_EN: on underflow, sal holds the sign-extended difference instead of 0.
module resta_seq
  import resta_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] yi,
  output logic [OUT_W-1:0] sal,
  output logic             done,
  output logic             busy,
  output logic             neg
);

  localparam int CNT_W = clog2(WIDTH);

  state_t             state, state_next;
  logic               init_q;
  logic               start;
  logic [WIDTH-1:0]   x_sh, y_sh, res_sh;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               d, bout;
  logic [OUT_W-1:0]   sal_next;

  // Only a fresh 0->1 of init starts an operation; a level held across done does not.
  assign start    = init & ~init_q;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_sub_bit u_full_sub_bit (
    .a    (x_sh[0]),
    .b    (y_sh[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = SUB;
      SUB: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sal_next = '0;
    sal_next[WIDTH-1:0] = res_sh;
    if (borrow) begin
`ifdef RESTA_SIGNED_RESULT_EN
      // {1, d} sign-extended is all ones above the WIDTH-bit difference.
      sal_next = '1;
      sal_next[WIDTH-1:0] = res_sh;
`else
      sal_next = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      x_sh   <= '0;
      y_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      sal    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
    end else begin
      init_q <= init;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_sh   <= xi;
            y_sh   <= yi;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SUB: begin
          // Difference bits enter from the top; after WIDTH shifts they are LSB-aligned.
          res_sh <= {d, res_sh[WIDTH-1:1]};
          x_sh   <= x_sh >> 1;
          y_sh   <= y_sh >> 1;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          sal  <= sal_next;
          neg  <= borrow;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resta_seq.sv
// Self-checking bench for resta_seq: a 3-bit and an 8-bit instance against an arithmetic model.
module tb_resta_seq;
  import resta_pkg::*;

`ifdef RESTA_SIGNED_RESULT_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int WA  = WIDTH_DEFAULT;
  localparam int OWA = OUT_W_DEFAULT;
  localparam int WB  = 8;
  localparam int OWB = 16;

  logic            clk = 1'b0;
  logic            rst_a, init_a, done_a, busy_a, neg_a;
  logic [WA-1:0]   xi_a, yi_a;
  logic [OWA-1:0]  sal_a;
  logic            rst_b, init_b, done_b, busy_b, neg_b;
  logic [WB-1:0]   xi_b, yi_b;
  logic [OWB-1:0]  sal_b;

  int checks = 0;
  int errors = 0;

  bit          sel = 1'b0;
  logic [31:0] last_sal [2];
  logic [15:0] o_sal;
  logic        o_done, o_busy, o_neg;

  assign o_sal  = sel ? sal_b  : {{(16 - OWA){1'b0}}, sal_a};
  assign o_done = sel ? done_b : done_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_neg  = sel ? neg_b  : neg_a;

  always #5 clk = ~clk;

  resta_seq #(.WIDTH(WA), .OUT_W(OWA)) u_dut_a (
    .clk(clk), .rst(rst_a), .init(init_a), .xi(xi_a), .yi(yi_a),
    .sal(sal_a), .done(done_a), .busy(busy_a), .neg(neg_a)
  );

  resta_seq #(.WIDTH(WB), .OUT_W(OWB)) u_dut_b (
    .clk(clk), .rst(rst_b), .init(init_b), .xi(xi_b), .yi(yi_b),
    .sal(sal_b), .done(done_b), .busy(busy_b), .neg(neg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, result bus truncated to its width.
  function automatic logic [31:0] model_sal(input bit s, input int x, input int y);
    int ow;
    ow = s ? OWB : OWA;
    if (x >= y)    return 32'(x - y);
    if (SIGNED_EN) return 32'((x - y) & ((1 << ow) - 1));
    return 32'd0;
  endfunction

  task automatic drive(input bit s, input int x, input int y, input logic in);
    if (s) begin
      xi_b = x[WB-1:0]; yi_b = y[WB-1:0]; init_b = in;
    end else begin
      xi_a = x[WA-1:0]; yi_a = y[WA-1:0]; init_a = in;
    end
  endtask

  // One operation: raise init, scramble operands after capture, time done and busy.
  task automatic op(input bit s, input int x, input int y, input string tag);
    int w, n, busy_n;
    bit seen;
    w = s ? WB : WA;
    n = 0; busy_n = 0; seen = 1'b0;
    @(negedge clk);
    sel = s;
    drive(s, x, y, 1'b1);
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (o_busy) busy_n++;
      if (n == 2) begin
        check({tag, " sal_held"}, 32'(o_sal), last_sal[s]);
        drive(s, int'($urandom), int'($urandom), 1'b1);
      end
      if (o_done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(w + 2));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(w));
    check({tag, " sal"}, 32'(o_sal), model_sal(s, x, y));
    check({tag, " neg"}, 32'(o_neg), 32'(x < y));
    last_sal[s] = model_sal(s, x, y);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(o_done), 32'd0);
    drive(s, x, y, 1'b0);
  endtask

  initial begin
    int n, dones, hold_sal, x, y;
    last_sal[0] = 32'd0;
    last_sal[1] = 32'd0;
    rst_a = 1'b1; init_a = 1'b0; xi_a = '0; yi_a = '0;
    rst_b = 1'b1; init_b = 1'b1; xi_b = 8'd255; yi_b = 8'd0;

    repeat (2) @(negedge clk);
    sel = 1'b0;
    check("reset sal_a", 32'(sal_a), 32'd0);
    check("reset busy_a", 32'(busy_a), 32'd0);
    check("reset done_a", 32'(done_a), 32'd0);
    check("reset neg_a", 32'(neg_a), 32'd0);
    check("reset sal_b", 32'(sal_b), 32'd0);

    // init already high on the 8-bit unit when reset releases: that is a start.
    rst_a = 1'b0;
    rst_b = 1'b0;
    sel = 1'b1;
    n = 0;
    while (n < 40 && !done_b) begin
      @(negedge clk);
      n++;
    end
    check("b release_start latency", 32'(n), 32'(WB + 2));
    check("b 255-0 sal", 32'(sal_b), model_sal(1'b1, 255, 0));
    check("b 255-0 neg", 32'(neg_b), 32'd0);
    last_sal[1] = model_sal(1'b1, 255, 0);
    init_b = 1'b0;
    op(1'b1, 0, 1, "b 0-1");

    op(1'b0, 5, 3, "a 5-3");
    op(1'b0, 3, 5, "a 3-5");
    op(1'b0, 7, 7, "a 7-7");
    op(1'b0, 0, 7, "a 0-7");
    op(1'b0, 5, 3, "a 5-3 again");

    // Reset in the second SUB cycle: outputs clear at once, no done follows.
    sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 6, 1, 1'b1);
    repeat (2) @(negedge clk);
    check("rst busy_before", 32'(busy_a), 32'd1);
    #1;
    rst_a = 1'b1;
    init_a = 1'b0;
    #1;
    check("rst sal", 32'(sal_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst neg", 32'(neg_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    last_sal[0] = 32'd0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("rst no_done", 32'(dones), 32'd0);
    op(1'b0, 4, 4, "a 4-4 after rst");

    // init held high ~20 cycles with a re-rise while busy and xi changed mid-op.
    @(negedge clk);
    sel = 1'b0;
    drive(1'b0, 3, 5, 1'b1);
    dones = 0;
    hold_sal = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) drive(1'b0, 7, 0, 1'b0);
      if (i == 3) drive(1'b0, 7, 0, 1'b1);
      if (done_a) begin
        dones++;
        hold_sal = int'(sal_a);
      end
    end
    check("hold done_count", 32'(dones), 32'd1);
    check("hold sal", 32'(hold_sal), model_sal(1'b0, 3, 5));
    last_sal[0] = model_sal(1'b0, 3, 5);
    init_a = 1'b0;

    for (int i = 0; i < 12; i++) begin
      x = int'($urandom_range(7));
      y = int'($urandom_range(7));
      op(1'b0, x, y, "a rand");
    end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(255));
      y = int'($urandom_range(255));
      op(1'b1, x, y, "b rand");
    end
    op(1'b1, 0, 255, "b 0-255");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
